seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Parametrised serial pattern detector. It watches a 1-bit input stream and flags every occurrence of a fixed N-bit pattern, in either overlapping or non-overlapping mode. It also keeps a saturating count of matches. The block sits on the serial-input side of the shift-register datapath and extends the fixed 2-bit-state Mealy detector to arbitrary pattern length, adds qualified input and a match counter.

Parameters:
N, 4, pattern length in bits; legal range 2..32.
PATTERN, 4'b1011, pattern to detect, N bits wide; the MSB is the oldest bit received.
OVERLAP, 1, 1 = the bits of a match may start the next match; 0 = the window is flushed after each match.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
r  input  1  synchronous active-high reset.
en  input  1  bit-valid qualifier; i is sampled only when en=1.
i  input  1  serial data bit.
o  output  1  match pulse, registered.
cnt  output  CNT_W  saturating match count.
armed  output  1  window holds N valid bits (state ARMED).

Behaviour:
- Reset: clk rising edge with r=1 sets window=0, fill=0, o=0, cnt=0, state=FILL.
  - r has priority over en.
  - Reset mid-stream discards all partial bits.
- Internal state:
  - window[N-1:0] shift register of accepted bits.
  - fill counter, 0..N, width clog2(N+1).
  - FSM states FILL (fill<N) and ARMED (fill==N).
  - armed = (state==ARMED).
- On an accepted bit (en=1, r=0):
  - win_n = {window[N-2:0], i}.
  - fill_n = min(fill+1, N).
  - hit = (fill_n==N) && (win_n==PATTERN).
- Registered updates on an accepted bit:
  - o <= hit.
  - if hit and cnt != all-ones: cnt <= cnt+1. At all-ones, cnt holds (saturates, no wrap).
  - OVERLAP=1: window <= win_n, fill <= fill_n. State goes to or stays in ARMED once fill_n==N.
  - OVERLAP=0 with hit: window <= 0, fill <= 0, state <= FILL. The next match needs N fresh accepted bits.
  - OVERLAP=0 without hit: same as OVERLAP=1.
- en=0: o <= 0; window, fill, cnt and state hold. Gaps in en are transparent to matching.
- Latency:
  - o is high for exactly one clk cycle, starting at the edge that samples the final pattern bit.
  - Back-to-back matches on consecutive accepted bits give consecutive o pulses. This is possible only with OVERLAP=1 and a periodic pattern, e.g. all-ones.
- Leading bits: no match is ever reported before N bits have been accepted since reset or flush. The zero-initialised window must not produce false hits, e.g. for PATTERN=0000.
- FSM transitions:
  - FILL->ARMED when fill_n==N and the window is not flushed.
  - ARMED->FILL only on reset or a non-overlap flush.
  - ARMED->ARMED otherwise.
- Width rules: the compare is an exact N-bit compare; cnt is unsigned.
- Outputs depend only on registers; no combinational path from i to o.

Test Plan:
1. N=4, PATTERN=1011, OVERLAP=1, en=1, stream 1,0,1,1,0,1,1 -> o pulses after bits 4 and 7; cnt=2; armed=1 from bit 4 onward.
2. Same stream with OVERLAP=0 -> single o pulse after bit 4; armed drops to 0 after that match; cnt=1. Appending 1,0,1,1 gives a second pulse on the 4th appended bit; cnt=2.
3. PATTERN=0000, OVERLAP=1, reset then stream 0,0,0,0,0 -> no pulse on bits 1-3; pulses after bits 4 and 5; cnt=2.
4. OVERLAP=1, stream 1,0,1,1 with en=0 for 3 cycles inserted between bits 2 and 3 (i toggling while en=0) -> one pulse, aligned with bit 4's sampling edge; o=0 and armed/cnt unchanged during the gap.
5. CNT_W=2, N=2, PATTERN=11, OVERLAP=1, five consecutive 1s -> four o pulses; cnt goes 1,2,3,3 (saturates at 3).
6. Stream 1,0,1, then r=1 with en=1 and i=1 in the same cycle, then 1 -> no match; fill=1, armed=0, cnt=0, o=0 after reset. A following 0,1,1 produces a match on the final 1.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial N-bit pattern detector with qualified input, overlap/flush modes and a saturating match counter.
// o is registered and pulses on the edge that samples the last pattern bit.
module seq_detector_param #(
   parameter int             N       = 4,
   parameter logic [N-1:0]   PATTERN = 4'b1011,
   parameter bit             OVERLAP = 1'b1,
   parameter int             CNT_W   = 8
) (
   input  logic             clk,
   input  logic             r,
   input  logic             en,
   input  logic             i,
   output logic             o,
   output logic [CNT_W-1:0] cnt,
   output logic             armed
);

   localparam int FW = $clog2(N + 1);
   localparam logic [FW-1:0] FILL_FULL = FW'(N);

   typedef enum logic {FILL, ARMED} state_t;

   state_t             state_p0, state_d;
   logic [N-1:0]       window_p0, window_d;
   logic [FW-1:0]      fill_p0, fill_d;
   logic               o_p0, o_d;
   logic [CNT_W-1:0]   cnt_p0, cnt_d;

   logic [N-1:0]       win_n;
   logic [FW-1:0]      fill_n;
   logic               hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [FW-1:0] sat_fill(input logic [FW-1:0] f);
      return (f == FILL_FULL) ? FILL_FULL : f + 1'b1;
   endfunction

   // Candidate window for the bit being offered; the fill gate keeps the
   // zero-initialised window from matching an all-zero pattern early.
   always_comb begin
      win_n  = {window_p0[N-2:0], i};
      fill_n = sat_fill(fill_p0);
      hit    = (fill_n == FILL_FULL) && (win_n == PATTERN);
   end

   always_comb begin
      state_d  = state_p0;
      window_d = window_p0;
      fill_d   = fill_p0;
      o_d      = 1'b0;
      cnt_d    = cnt_p0;
      if (en) begin
         o_d = hit;
         if (hit)
            cnt_d = sat_inc(cnt_p0);
         if (hit && !OVERLAP) begin
            window_d = '0;
            fill_d   = '0;
            state_d  = FILL;
         end else begin
            window_d = win_n;
            fill_d   = fill_n;
            case (state_p0)
               FILL:    state_d = (fill_n == FILL_FULL) ? ARMED : FILL;
               ARMED:   state_d = ARMED;
               default: state_d = FILL;
            endcase
         end
      end
   end

   // Register stage: all state and outputs update on the rising edge.
   always_ff @(posedge clk) begin
      if (r) begin
         state_p0  <= FILL;
         window_p0 <= '0;
         fill_p0   <= '0;
         o_p0      <= 1'b0;
         cnt_p0    <= '0;
      end else begin
         state_p0  <= state_d;
         window_p0 <= window_d;
         fill_p0   <= fill_d;
         o_p0      <= o_d;
         cnt_p0    <= cnt_d;
      end
   end

   assign o     = o_p0;
   assign cnt   = cnt_p0;
   assign armed = (state_p0 == ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: four parameterisations share one stimulus stream,
// each step checks the instance the scenario targets against hand-computed values.
module tb_seq_detector_param;

   logic clk = 1'b0;
   logic r   = 1'b1;
   logic en  = 1'b0;
   logic i   = 1'b0;

   logic       o_ov, o_no, o_z, o_s;
   logic [7:0] cnt_ov, cnt_no, cnt_z;
   logic [1:0] cnt_s;
   logic       armed_ov, armed_no, armed_z, armed_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
      .clk(clk), .r(r), .en(en), .i(i), .o(o_ov), .cnt(cnt_ov), .armed(armed_ov));
   seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
      .clk(clk), .r(r), .en(en), .i(i), .o(o_no), .cnt(cnt_no), .armed(armed_no));
   seq_detector_param #(.N(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8)) u_z (
      .clk(clk), .r(r), .en(en), .i(i), .o(o_z), .cnt(cnt_z), .armed(armed_z));
   seq_detector_param #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_s (
      .clk(clk), .r(r), .en(en), .i(i), .o(o_s), .cnt(cnt_s), .armed(armed_s));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic rr, input logic ee, input logic ii);
      @(negedge clk);
      r  = rr;
      en = ee;
      i  = ii;
      @(posedge clk);
      #1;
   endtask

   task automatic bits(input logic ii);
      step(1'b0, 1'b1, ii);
   endtask

   initial begin
      // Reset state
      step(1'b1, 1'b0, 1'b0);
      chk("rst_o_ov", o_ov, 0);
      chk("rst_cnt_ov", cnt_ov, 0);
      chk("rst_armed_ov", armed_ov, 0);
      chk("rst_o_no", o_no, 0);
      chk("rst_armed_z", armed_z, 0);
      chk("rst_cnt_s", cnt_s, 0);

      // Overlap vs non-overlap on 1,0,1,1,0,1,1
      bits(1); bits(0); bits(1);
      chk("t1_b3_o", o_ov, 0);
      chk("t1_b3_armed", armed_ov, 0);
      bits(1);
      chk("t1_b4_o", o_ov, 1);
      chk("t1_b4_cnt", cnt_ov, 1);
      chk("t1_b4_armed", armed_ov, 1);
      chk("t2_b4_o", o_no, 1);
      chk("t2_b4_cnt", cnt_no, 1);
      chk("t2_b4_armed", armed_no, 0);
      bits(0);
      chk("t1_b5_o", o_ov, 0);
      chk("t2_b5_o", o_no, 0);
      bits(1);
      chk("t1_b6_o", o_ov, 0);
      chk("t1_b6_armed", armed_ov, 1);
      bits(1);
      chk("t1_b7_o", o_ov, 1);
      chk("t1_b7_cnt", cnt_ov, 2);
      chk("t2_b7_o", o_no, 0);
      chk("t2_b7_cnt", cnt_no, 1);
      bits(1);
      chk("t2_b8_o", o_no, 0);
      chk("t2_b8_armed", armed_no, 1);
      bits(0); bits(1);
      chk("t2_b10_o", o_no, 0);
      bits(1);
      chk("t2_b11_o", o_no, 1);
      chk("t2_b11_cnt", cnt_no, 2);
      chk("t2_b11_armed", armed_no, 0);

      // All-zero pattern must not fire from the reset window
      step(1'b1, 1'b0, 1'b0);
      bits(0); bits(0); bits(0);
      chk("t3_b3_o", o_z, 0);
      chk("t3_b3_cnt", cnt_z, 0);
      chk("t3_b3_armed", armed_z, 0);
      bits(0);
      chk("t3_b4_o", o_z, 1);
      chk("t3_b4_cnt", cnt_z, 1);
      bits(0);
      chk("t3_b5_o", o_z, 1);
      chk("t3_b5_cnt", cnt_z, 2);

      // Saturating counter, CNT_W=2
      step(1'b1, 1'b0, 1'b0);
      bits(1);
      chk("t5_b1_o", o_s, 0);
      chk("t5_b1_cnt", cnt_s, 0);
      bits(1);
      chk("t5_b2_o", o_s, 1);
      chk("t5_b2_cnt", cnt_s, 1);
      bits(1);
      chk("t5_b3_cnt", cnt_s, 2);
      bits(1);
      chk("t5_b4_cnt", cnt_s, 3);
      bits(1);
      chk("t5_b5_o", o_s, 1);
      chk("t5_b5_cnt", cnt_s, 3);

      // en gaps are transparent; i toggles while en=0
      step(1'b1, 1'b0, 1'b0);
      bits(1); bits(0);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, k[0]);
         chk("t4_gap_o", o_ov, 0);
         chk("t4_gap_armed", armed_ov, 0);
         chk("t4_gap_cnt", cnt_ov, 0);
      end
      bits(1);
      chk("t4_b3_o", o_ov, 0);
      bits(1);
      chk("t4_b4_o", o_ov, 1);
      chk("t4_b4_cnt", cnt_ov, 1);
      step(1'b0, 1'b0, 1'b1);
      chk("t4_post_o", o_ov, 0);
      chk("t4_post_cnt", cnt_ov, 1);
      chk("t4_post_armed", armed_ov, 1);

      // Reset has priority over an accepted bit and discards the partial window
      step(1'b1, 1'b0, 1'b0);
      bits(1); bits(0); bits(1);
      step(1'b1, 1'b1, 1'b1);
      chk("t6_rst_o", o_ov, 0);
      chk("t6_rst_cnt", cnt_ov, 0);
      chk("t6_rst_armed", armed_ov, 0);
      bits(1);
      chk("t6_b1_o", o_ov, 0);
      chk("t6_b1_armed", armed_ov, 0);
      bits(0); bits(1);
      chk("t6_b3_o", o_ov, 0);
      bits(1);
      chk("t6_b4_o", o_ov, 1);
      chk("t6_b4_cnt", cnt_ov, 1);
      chk("t6_b4_armed", armed_ov, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
